// File: rtl/wasm_core_if.sv
// wasm_core_if: wide-read program ROM port between wasm_core (master) and genrom (slave).
interface wasm_core_if #(
    parameter int MEM_DEPTH = 4
);
    logic [MEM_DEPTH:0] mem_addr;
    logic [3:0]         mem_extra;
    logic [127:0]       mem_data;
    logic               mem_error;

    modport master (output mem_addr, mem_extra, input mem_data, mem_error);
    modport slave  (input mem_addr, mem_extra, output mem_data, mem_error);
endinterface

// File: rtl/wasm_core.sv
// wasm_core: minimal WebAssembly stack-machine core, one instruction per FETCH/EXEC pair.
// Define WASM_CORE_BITWISE_EN to implement i32.and/or/xor (0x71-0x73); otherwise they trap.
module wasm_core #(
    parameter bit HAS_FPU     = 1'b1,
    parameter bit USE_64B     = 1'b1,
    parameter int MEM_DEPTH   = 4,
    parameter int STACK_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    wasm_core_if.master  mem,
    output logic [63:0]  result,
    output logic [1:0]   result_type,
    output logic         result_empty,
    output logic [3:0]   trap
);
    localparam int AW  = MEM_DEPTH + 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = $clog2(STACK_DEPTH);
    localparam logic [1:0] T_I32 = 2'd0, T_I64 = 2'd1, T_F32 = 2'd2, T_F64 = 2'd3;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_TRAP} state_t;

    state_t         state  = S_FETCH;
    logic [AW-1:0]  pc     = '0;
    logic [SPW-1:0] sp     = '0;
    logic [3:0]     trap_q = '0;
    logic [63:0]    stk_val [STACK_DEPTH];
    logic [1:0]     stk_ty  [STACK_DEPTH];

    logic [IW-1:0] top_i, nxt_i, wr_i;
    logic [63:0]   a, b, pv, leb_val;
    logic [1:0]    ta, tb, pt, pop_n;
    logic [3:0]    tc, len, leb_len;
    logic          push, halt, leb_done, leb_neg;

    assign top_i = IW'(sp - 1'b1);
    assign nxt_i = IW'(sp - 2'd2);
    assign wr_i  = IW'(sp - SPW'(pop_n));
    assign b  = stk_val[top_i];
    assign tb = stk_ty[top_i];
    assign a  = stk_val[nxt_i];
    assign ta = stk_ty[nxt_i];

    // Signed LEB128 scan over the immediate bytes; an unterminated window leaves leb_done low.
    always_comb begin
        leb_val  = '0;
        leb_len  = '0;
        leb_done = 1'b0;
        leb_neg  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (!leb_done) begin
                leb_val  = leb_val | (64'(mem.mem_data[8*i+8 +: 7]) << (7 * i));
                leb_len  = 4'(i + 1);
                leb_done = !mem.mem_data[8*i+15];
                leb_neg  = mem.mem_data[8*i+14];
            end
        end
        if (leb_neg && leb_len < 4'd10) leb_val = leb_val | ({64{1'b1}} << (7 * leb_len));
    end

    function automatic logic [3:0] bin_tc(input logic [1:0] ty);
        return (sp < SPW'(2)) ? 4'd2 : (ta != ty || tb != ty) ? 4'd6 : 4'd0;
    endfunction

    always_comb begin
        tc    = 4'd0;
        len   = 4'd1;
        pop_n = 2'd0;
        push  = 1'b0;
        halt  = 1'b0;
        pv    = '0;
        pt    = T_I32;
        case (mem.mem_data[7:0])
            8'h00: tc = 4'd1;
            8'h01: ;
            8'h0B: halt = 1'b1;
            8'h1A: begin
                tc    = (sp == '0) ? 4'd2 : 4'd0;
                pop_n = 2'd1;
            end
            8'h41: begin
                tc   = (leb_done && leb_len <= 4'd5) ? 4'd0 : 4'd4;
                push = 1'b1;
                pv   = {32'd0, leb_val[31:0]};
                len  = leb_len + 4'd1;
            end
            8'h42: begin
                tc   = (USE_64B && leb_done && leb_len <= 4'd10) ? 4'd0 : 4'd4;
                push = 1'b1;
                pv   = leb_val;
                pt   = T_I64;
                len  = leb_len + 4'd1;
            end
            8'h43: begin
                tc   = HAS_FPU ? 4'd0 : 4'd4;
                push = 1'b1;
                pv   = {32'd0, mem.mem_data[39:8]};
                pt   = T_F32;
                len  = 4'd5;
            end
            8'h44: begin
                tc   = HAS_FPU ? 4'd0 : 4'd4;
                push = 1'b1;
                pv   = mem.mem_data[71:8];
                pt   = T_F64;
                len  = 4'd9;
            end
            8'h6A, 8'h6B: begin
                tc    = bin_tc(T_I32);
                pop_n = 2'd2;
                push  = 1'b1;
                pv    = {32'd0, mem.mem_data[0] ? a[31:0] - b[31:0] : a[31:0] + b[31:0]};
            end
`ifdef WASM_CORE_BITWISE_EN
            8'h71, 8'h72, 8'h73: begin
                tc    = bin_tc(T_I32);
                pop_n = 2'd2;
                push  = 1'b1;
                pv    = {32'd0, (mem.mem_data[1:0] == 2'd1) ? a[31:0] & b[31:0] :
                                (mem.mem_data[1:0] == 2'd2) ? a[31:0] | b[31:0] : a[31:0] ^ b[31:0]};
            end
`endif
            8'h7C, 8'h7D: begin
                tc    = USE_64B ? bin_tc(T_I64) : 4'd4;
                pop_n = 2'd2;
                push  = 1'b1;
                pv    = mem.mem_data[0] ? a - b : a + b;
                pt    = T_I64;
            end
            default: tc = 4'd4;
        endcase
        if (tc == 4'd0 && push && pop_n == 2'd0 && sp == SPW'(STACK_DEPTH)) tc = 4'd3;
        if (mem.mem_error) tc = 4'd5;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= '0;
            sp     <= '0;
            trap_q <= '0;
        end else begin
            case (state)
                S_FETCH: state <= S_EXEC;
                S_EXEC: begin
                    if (tc != 4'd0) begin
                        trap_q <= tc;
                        state  <= S_TRAP;
                    end else if (halt) begin
                        state <= S_HALT;
                    end else begin
                        pc <= pc + AW'(len);
                        sp <= sp - SPW'(pop_n) + SPW'(push);
                        if (push) begin
                            stk_val[wr_i] <= pv;
                            stk_ty[wr_i]  <= pt;
                        end
                        state <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_empty  = (sp == '0);
    assign result        = result_empty ? '0 : stk_val[top_i];
    assign result_type   = result_empty ? T_I32 : stk_ty[top_i];
    assign trap          = trap_q;
    assign mem.mem_addr  = pc;
    assign mem.mem_extra = 4'd15;
endmodule

// File: tb/tb_wasm_core.sv
// tb_wasm_core: directed-vector bench for wasm_core with a 256-byte registered ROM model.
module tb_wasm_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] result;
    logic [1:0]  result_type;
    logic        result_empty;
    logic [3:0]  trap;
    logic [7:0]  rom [256];
    logic [7:0]  code [$];
    int          rom_len = 256;
    int          checks = 0;
    int          fails = 0;

    wasm_core_if #(.MEM_DEPTH(7)) mem ();

    wasm_core #(.HAS_FPU(1'b1), .USE_64B(1'b1), .MEM_DEPTH(7), .STACK_DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (mem),
        .result       (result),
        .result_type  (result_type),
        .result_empty (result_empty),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    // ROM returns the 16-byte window one cycle after the address.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) mem.mem_data[8*i +: 8] <= rom[8'(int'(mem.mem_addr) + i)];
        mem.mem_error <= (int'(mem.mem_addr) >= rom_len);
    end

    task automatic start();
        foreach (rom[i]) rom[i] = 8'h00;
        foreach (code[i]) rom[8'(i)] = code[i];
        rom_len = 256;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        code = '{8'h41, 8'h05, 8'h0B};
        start();
        checks++; if (result !== 64'd0) begin fails++; $display("FAIL reset_result got=%0h want=0", result); end
        checks++; if (result_type !== 2'd0) begin fails++; $display("FAIL reset_type got=%0d want=0", result_type); end
        checks++; if (result_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%0b want=1", result_empty); end
        checks++; if (trap !== 4'd0) begin fails++; $display("FAIL reset_trap got=%0d want=0", trap); end
        checks++; if (mem.mem_addr !== 8'd0) begin fails++; $display("FAIL reset_addr got=%0d want=0", mem.mem_addr); end
        checks++; if (mem.mem_extra !== 4'd15) begin fails++; $display("FAIL mem_extra got=%0d want=15", mem.mem_extra); end
    endtask

    task automatic test_add();
        code = '{8'h41, 8'h01, 8'h41, 8'h02, 8'h6A, 8'h0B};
        start();
        step(4);
        checks++; if (result !== 64'd2) begin fails++; $display("FAIL add_second_push got=%0h want=2", result); end
        step(2);
        checks++; if (result !== 64'd3) begin fails++; $display("FAIL add_6_edges got=%0h want=3", result); end
        step(6);
        checks++; if ({result_type, result_empty, trap} !== 7'd0) begin fails++; $display("FAIL add_status got=%0h want=0", {result_type, result_empty, trap}); end
        checks++; if (result !== 64'd3) begin fails++; $display("FAIL add_halt_hold got=%0h want=3", result); end
        checks++; if (mem.mem_addr !== 8'd5) begin fails++; $display("FAIL halt_pc got=%0d want=5", mem.mem_addr); end
    endtask

    task automatic test_reset_midway();
        code = '{8'h41, 8'h01, 8'h41, 8'h02, 8'h6A, 8'h0B};
        start();
        step(3);
        start();
        checks++; if (result_empty !== 1'b1 || mem.mem_addr !== 8'd0) begin fails++; $display("FAIL midreset got empty=%0b pc=%0d want empty=1 pc=0", result_empty, mem.mem_addr); end
        step(6);
        checks++; if (result !== 64'd3) begin fails++; $display("FAIL midreset_rerun got=%0h want=3", result); end
    endtask

    task automatic test_wrap();
        code = '{8'h41, 8'h7F, 8'h41, 8'h01, 8'h6A, 8'h0B};
        start();
        step(8);
        checks++; if (result !== 64'd0 || result_empty !== 1'b0 || result_type !== 2'd0) begin fails++; $display("FAIL wrap_add got=%0h empty=%0b want=0 empty=0", result, result_empty); end
        code = '{8'h41, 8'h00, 8'h41, 8'h01, 8'h6B, 8'h0B};
        start();
        step(8);
        checks++; if (result !== 64'h0000_0000_FFFF_FFFF) begin fails++; $display("FAIL wrap_sub got=%0h want=ffffffff", result); end
    endtask

    task automatic test_i64();
        code = '{8'h42, 8'h80, 8'h01, 8'h42, 8'h7F, 8'h7C, 8'h42, 8'h05, 8'h7D, 8'h0B};
        start();
        step(4);
        checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF || result_type !== 2'd1) begin fails++; $display("FAIL i64_const got=%0h/%0d want=ffffffffffffffff/1", result, result_type); end
        step(2);
        checks++; if (result !== 64'd127) begin fails++; $display("FAIL i64_add got=%0h want=7f", result); end
        step(6);
        checks++; if (result !== 64'd122 || result_type !== 2'd1 || trap !== 4'd0) begin fails++; $display("FAIL i64_sub got=%0h/%0d trap=%0d want=7a/1 trap=0", result, result_type, trap); end
    endtask

    task automatic test_leb();
        code = '{8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h0B};
        start();
        step(2);
        checks++; if (result !== 64'h0000_0000_FFFF_FFFF || trap !== 4'd0) begin fails++; $display("FAIL leb_i32_5b got=%0h trap=%0d want=ffffffff trap=0", result, trap); end
        code = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        start();
        step(2);
        checks++; if (trap !== 4'd4) begin fails++; $display("FAIL leb_i32_6b got=%0d want=4", trap); end
        code = '{8'h42, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h0B};
        start();
        step(2);
        checks++; if (result !== 64'h8000_0000_0000_0000 || trap !== 4'd0) begin fails++; $display("FAIL leb_i64_10b got=%0h trap=%0d want=8000000000000000 trap=0", result, trap); end
        code = '{8'h42, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        start();
        step(2);
        checks++; if (trap !== 4'd4) begin fails++; $display("FAIL leb_i64_11b got=%0d want=4", trap); end
    endtask

    task automatic test_float();
        code = '{8'h43, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'hF0, 8'h3F, 8'h1A, 8'h0B};
        start();
        step(4);
        checks++; if (result !== 64'h3FF0_0000_0000_0000 || result_type !== 2'd3) begin fails++; $display("FAIL f64_const got=%0h/%0d want=3ff0000000000000/3", result, result_type); end
        step(2);
        checks++; if (result !== 64'h3F80_0000 || result_type !== 2'd2) begin fails++; $display("FAIL f32_after_drop got=%0h/%0d want=3f800000/2", result, result_type); end
        step(4);
        checks++; if (trap !== 4'd0 || mem.mem_addr !== 8'd15) begin fails++; $display("FAIL float_halt got trap=%0d pc=%0d want trap=0 pc=15", trap, mem.mem_addr); end
    endtask

    task automatic test_mismatch();
        code = '{8'h42, 8'h05, 8'h41, 8'h01, 8'h6A};
        start();
        step(6);
        checks++; if (trap !== 4'd6) begin fails++; $display("FAIL mismatch_trap got=%0d want=6", trap); end
        step(4);
        checks++; if (result !== 64'd1 || result_type !== 2'd0 || result_empty !== 1'b0) begin fails++; $display("FAIL mismatch_frozen got=%0h/%0d/%0b want=1/0/0", result, result_type, result_empty); end
    endtask

    task automatic test_underflow();
        code = '{8'h6A};
        start();
        step(1);
        checks++; if (trap !== 4'd0) begin fails++; $display("FAIL underflow_early got=%0d want=0", trap); end
        step(1);
        checks++; if (trap !== 4'd2 || result_empty !== 1'b1) begin fails++; $display("FAIL underflow_add got=%0d empty=%0b want=2 empty=1", trap, result_empty); end
        code = '{8'h41, 8'h01, 8'h6B};
        start();
        step(4);
        checks++; if (trap !== 4'd2 || result !== 64'd1) begin fails++; $display("FAIL underflow_one got=%0d res=%0h want=2 res=1", trap, result); end
        code = '{8'h1A};
        start();
        step(2);
        checks++; if (trap !== 4'd2) begin fails++; $display("FAIL drop_empty got=%0d want=2", trap); end
    endtask

    task automatic test_misc_traps();
        code = '{8'h00};
        start();
        step(2);
        checks++; if (trap !== 4'd1) begin fails++; $display("FAIL unreachable got=%0d want=1", trap); end
        code = '{8'hFF};
        start();
        step(6);
        checks++; if (trap !== 4'd4 || mem.mem_addr !== 8'd0) begin fails++; $display("FAIL invalid_op got=%0d pc=%0d want=4 pc=0", trap, mem.mem_addr); end
    endtask

    task automatic test_overflow();
        code = {};
        for (int i = 0; i < 17; i++) begin
            code.push_back(8'h41);
            code.push_back(8'h01);
        end
        code.push_back(8'h0B);
        start();
        step(32);
        checks++; if (trap !== 4'd0 || result !== 64'd1) begin fails++; $display("FAIL overflow_16th got trap=%0d res=%0h want trap=0 res=1", trap, result); end
        step(2);
        checks++; if (trap !== 4'd3 || mem.mem_addr !== 8'd32) begin fails++; $display("FAIL overflow_17th got trap=%0d pc=%0d want trap=3 pc=32", trap, mem.mem_addr); end
        start();
        checks++; if (trap !== 4'd0 || result_empty !== 1'b1) begin fails++; $display("FAIL overflow_reset got trap=%0d empty=%0b want trap=0 empty=1", trap, result_empty); end
        step(2);
        checks++; if (result !== 64'd1 || result_empty !== 1'b0) begin fails++; $display("FAIL overflow_rerun got=%0h empty=%0b want=1 empty=0", result, result_empty); end
    endtask

    task automatic test_bitwise();
        code = '{8'h41, 8'h0C, 8'h41, 8'h0A, 8'h71, 8'h41, 8'h03, 8'h72, 8'h41, 8'h05, 8'h73, 8'h0B};
        start();
        step(6);
`ifdef WASM_CORE_BITWISE_EN
        checks++; if (result !== 64'd8 || trap !== 4'd0) begin fails++; $display("FAIL bit_and got=%0h trap=%0d want=8 trap=0", result, trap); end
        step(4);
        checks++; if (result !== 64'd11) begin fails++; $display("FAIL bit_or got=%0h want=b", result); end
        step(4);
        checks++; if (result !== 64'd14) begin fails++; $display("FAIL bit_xor got=%0h want=e", result); end
`else
        checks++; if (trap !== 4'd4 || result !== 64'd10) begin fails++; $display("FAIL bit_disabled got trap=%0d res=%0h want trap=4 res=a", trap, result); end
`endif
    endtask

    task automatic test_mem_error();
        code = '{8'h01, 8'h01, 8'h0B};
        start();
        rom_len = 1;
        step(2);
        checks++; if (trap !== 4'd0 || mem.mem_addr !== 8'd1) begin fails++; $display("FAIL memerr_first got trap=%0d pc=%0d want trap=0 pc=1", trap, mem.mem_addr); end
        step(2);
        checks++; if (trap !== 4'd5) begin fails++; $display("FAIL memerr_trap got=%0d want=5", trap); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_reset_midway();
        test_wrap();
        test_i64();
        test_leb();
        test_float();
        test_mismatch();
        test_underflow();
        test_misc_traps();
        test_overflow();
        test_bitwise();
        test_mem_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/wasm_core.md
# wasm_core

Minimal WebAssembly stack-machine execution core. Fetches bytecode from a byte-addressed, wide-read ROM port, decodes one instruction per fetch, executes it on an internal typed operand stack, and exposes top-of-stack plus trap status. Sits between the program ROM (`genrom`) and the system/host logic that consumes the result.

## Interface
- `HAS_FPU`, 1: 1 = accept `f32.const`/`f64.const`; 0 = those opcodes trap.
- `USE_64B`, 1: 1 = accept `i64.const`, `i64.add`, `i64.sub`; 0 = those opcodes trap.
- `MEM_DEPTH`, 4: memory address MSB index; address is MEM_DEPTH+1 bits.
- `STACK_DEPTH`, 16: operand stack entries, each 64-bit value plus 2-bit type.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `result` out 64: top-of-stack value; i32 values zero-extended; 0 when stack empty.
- `result_type` out 2: top-of-stack type: i32=0, i64=1, f32=2, f64=3; 0 when empty.
- `result_empty` out 1: 1 when stack holds no entries.
- `trap` out 4: 0 none, 1 unreachable, 2 stack underflow, 3 stack overflow, 4 invalid/malformed opcode, 5 memory error, 6 type mismatch.
- `mem_addr` out MEM_DEPTH+1: byte address of fetch (= PC).
- `mem_extra` out 4: extra bytes requested beyond the first; driven constant 15 (16-byte window).
- `mem_data` in 128: fetched bytes, little-endian: byte at `mem_addr` in [7:0], next byte in [15:8], etc.; valid one cycle after address.
- `mem_error` in 1: qualifies `mem_data`; 1 = fetch out of bounds.

## Operation
- State machine: FETCH -> EXEC -> FETCH ...; terminal states HALT and TRAP.
- FETCH: drive `mem_addr`=PC; go to EXEC.
- EXEC: if `mem_error`, trap 5. Else decode byte 0 of `mem_data`, execute, PC += instruction length (wraps modulo 2^(MEM_DEPTH+1)), return to FETCH.
- Opcodes: 0x00 unreachable (trap 1); 0x01 nop; 0x0B end (-> HALT, PC frozen); 0x1A drop; 0x41 i32.const (signed LEB128, 1-5 bytes); 0x42 i64.const (1-10 bytes); 0x43 f32.const (4 raw bytes); 0x44 f64.const (8 raw bytes); 0x6A i32.add; 0x6B i32.sub; 0x71/0x72/0x73 i32.and/or/xor; 0x7C i64.add; 0x7D i64.sub. Anything else: trap 4.
- LEB128 longer than the type allows, or not terminated within the window: trap 4.
- i32 arithmetic mod 2^32, result stored zero-extended; i64 mod 2^64. No overflow traps.
- Binary ops: pop b (top), pop a, push a op b. Fewer than two entries: trap 2. Operand types not both the op's type: trap 6. Push onto full stack: trap 3. `drop` on empty: trap 2.
- Trap: `trap` latched nonzero and sticky; stack, PC frozen; state TRAP. HALT: outputs hold, no further fetch.
- Only `reset` leaves HALT/TRAP.

## Timing
- Reset (sync, and also register power-up init values): PC=0, state=FETCH, stack empty, `result`=0, `result_type`=0, `result_empty`=1, `trap`=0.
- Each instruction costs exactly 2 cycles (FETCH, EXEC); outputs update at the end of the EXEC cycle.
- `i32.const 1; i32.const 2; i32.add; end` from PC 0: `result`=3 valid after 6 edges, halted after 8.
- Reset asserted mid-instruction: aborts it; next cycle state as above.
- `result`, `result_type`, `result_empty` are registered/derived from registered stack pointer only (no combinational path from `mem_data`).

## Configuration
- `WASM_CORE_BITWISE_EN`: defined -> 0x71/0x72/0x73 implemented as i32 and/or/xor; undefined -> those opcodes trap 4.

## Test plan
- Bytes 41 01 41 02 6A 0B -> after 8 cycles `result`=3, `result_type`=0, `result_empty`=0, `trap`=0.
- 41 7F 41 01 6A 0B (-1 + 1) -> `result`=0, `result_type`=0, `result_empty`=0; then 41 00 41 01 6B 0B -> `result`=0x00000000FFFFFFFF.
- 42 05 41 01 6A -> `trap`=6, stack frozen with i32 1 on top.
- 6A as first instruction -> `trap`=2 after 2 cycles, `result_empty`=1; 00 -> `trap`=1; FF -> `trap`=4.
- 17 consecutive `41 01` with STACK_DEPTH=16 -> `trap`=3 on the 17th push; `reset` pulse -> `trap`=0, `result_empty`=1, re-executes from PC 0.
- With `WASM_CORE_BITWISE_EN`: 41 0C 41 0A 71 0B -> `result`=8; without: `trap`=4.
